// File: rtl/axi_fifo_stream_reader.sv
// rtl/axi_fifo_stream_reader.sv - FIFO read-side drain engine to an AXI4-Stream master with burst tlast
module axi_fifo_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  output logic                  o_rd_en,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_m_axis_tvalid,
  input  logic                  i_m_axis_tready,
  output logic [DATA_WIDTH-1:0] o_m_axis_tdata,
  output logic                  o_m_axis_tlast,
  output logic [7:0]            o_beat_cnt,
  output logic                  o_burst_done
);

  localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] buf_mem [3];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [1:0]            occ;
  logic                  inflight;
  logic [7:0]            beat_cnt;
  logic                  burst_done;
  logic [2:0]            credit_used;
  logic                  push;
  logic                  pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credits count both buffered beats and the word still in the read pipeline.
  assign credit_used     = {1'b0, occ} + {2'b00, inflight};
  assign o_rd_en         = ~i_rst & i_enable & ~i_fifo_empty & (credit_used < 3'd3);
  assign push            = inflight;
  assign o_m_axis_tvalid = (occ != 2'd0);
  assign pop             = o_m_axis_tvalid & i_m_axis_tready;
  assign o_m_axis_tdata  = o_m_axis_tvalid ? buf_mem[rd_ptr] : '0;
  assign o_m_axis_tlast  = o_m_axis_tvalid & (beat_cnt == LAST_IDX);
  assign o_beat_cnt      = beat_cnt;
  assign o_burst_done    = burst_done;

  always_ff @(posedge i_clk) begin
    if (!i_rst && push) begin
      buf_mem[wr_ptr] <= i_rd_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      occ        <= 2'd0;
      inflight   <= 1'b0;
      beat_cnt   <= 8'd0;
      burst_done <= 1'b0;
    end else begin
      inflight   <= o_rd_en;
      burst_done <= pop & o_m_axis_tlast;
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        beat_cnt <= o_m_axis_tlast ? 8'd0 : beat_cnt + 8'd1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (credit_used <= 3'd3);
    end
  end

endmodule

// File: tb/tb_axi_fifo_stream_reader.sv
// tb/tb_axi_fifo_stream_reader.sv - directed self-checking bench for axi_fifo_stream_reader
module tb_axi_fifo_stream_reader;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        fifo_empty;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        tlast;
  logic [7:0]  beat_cnt;
  logic        burst_done;

  int total = 0;
  int bad   = 0;

  logic [31:0] fmem [256];
  int          fw = 0;
  int          fr = 0;

  logic [31:0] data_q [$];
  logic        last_q [$];
  int          done_cnt = 0;
  int          rd_cnt   = 0;

  int b;
  int r0;
  int d0;
  int k;

  axi_fifo_stream_reader #(.DATA_WIDTH(32), .BURST_LEN(4)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_enable        (enable),
    .i_fifo_empty    (fifo_empty),
    .o_rd_en         (rd_en),
    .i_rd_data       (rd_data),
    .o_m_axis_tvalid (tvalid),
    .i_m_axis_tready (tready),
    .o_m_axis_tdata  (tdata),
    .o_m_axis_tlast  (tlast),
    .o_beat_cnt      (beat_cnt),
    .o_burst_done    (burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty = (fw == fr);

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= fmem[fr];
      fr      <= fr + 1;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (tvalid && tready) begin
        data_q.push_back(tdata);
        last_q.push_back(tlast);
      end
      if (burst_done) done_cnt <= done_cnt + 1;
      if (rd_en) rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic push_word(input logic [31:0] v);
    fmem[fw] = v;
    fw = fw + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; tready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(32'(i));

    // reset held with FIFO non-empty and enable high
    repeat (3) begin
      @(negedge clk);
      check("rst_rd_en", {31'd0, rd_en}, 32'd0);
      check("rst_tvalid", {31'd0, tvalid}, 32'd0);
      check("rst_tlast", {31'd0, tlast}, 32'd0);
      check("rst_beat_cnt", {24'd0, beat_cnt}, 32'd0);
      check("rst_burst_done", {31'd0, burst_done}, 32'd0);
      check("rst_tdata", tdata, 32'd0);
    end
    rst = 1'b0;
    #1;
    check("rel_rd_en", {31'd0, rd_en}, 32'd1);

    // streaming: first word latency then 16 back-to-back beats
    @(negedge clk);
    check("lat_n1_tvalid", {31'd0, tvalid}, 32'd0);
    @(negedge clk);
    check("lat_n2_tvalid", {31'd0, tvalid}, 32'd1);
    check("lat_n2_tdata", tdata, 32'd0);
    repeat (16) @(negedge clk);
    check("stream_beats_b2b", 32'(data_q.size()), 32'd16);
    repeat (2) @(negedge clk);
    check("stream_done_cnt", 32'(done_cnt), 32'd4);
    check("stream_rd_cnt", 32'(rd_cnt), 32'd16);
    check("stream_idle_tvalid", {31'd0, tvalid}, 32'd0);
    check("stream_beat_cnt", {24'd0, beat_cnt}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i < data_q.size()) begin
        check("stream_data", data_q[i], 32'(i));
        check("stream_last", {31'd0, last_q[i]}, ((i % 4) == 3) ? 32'd1 : 32'd0);
      end
    end

    // backpressure: tready low for 6 cycles after first tvalid
    tready = 1'b0;
    b = data_q.size();
    r0 = rd_cnt;
    for (int i = 0; i < 16; i++) push_word(32'(i));
    k = 0;
    while (tvalid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("bp_tvalid_seen", {31'd0, tvalid}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("bp_hold_tdata", tdata, 32'd0);
      check("bp_hold_tvalid", {31'd0, tvalid}, 32'd1);
      @(negedge clk);
    end
    check("bp_rd_pulses", 32'(rd_cnt - r0), 32'd3);
    tready = 1'b1;
    k = 0;
    while (data_q.size() < b + 16 && k < 60) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check("bp_beat_count", 32'(data_q.size() - b), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (b + i < data_q.size()) check("bp_data", data_q[b + i], 32'(i));
    end

    // FIFO underflow mid-burst
    b = data_q.size();
    d0 = done_cnt;
    push_word(32'd100);
    push_word(32'd101);
    k = 0;
    while (data_q.size() < b + 2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("uf_tvalid_drop", {31'd0, tvalid}, 32'd0);
    check("uf_beat_hold", {24'd0, beat_cnt}, 32'd2);
    check("uf_tlast", {31'd0, tlast}, 32'd0);
    repeat (6) @(negedge clk);
    check("uf_beat_hold_late", {24'd0, beat_cnt}, 32'd2);
    push_word(32'd102);
    push_word(32'd103);
    k = 0;
    while (data_q.size() < b + 4 && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    check("uf_beat_count", 32'(data_q.size() - b), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (b + i < data_q.size()) begin
        check("uf_data", data_q[b + i], 32'(100 + i));
        check("uf_last", {31'd0, last_q[b + i]}, (i == 3) ? 32'd1 : 32'd0);
      end
    end
    check("uf_done", 32'(done_cnt - d0), 32'd1);
    check("uf_beat_wrap", {24'd0, beat_cnt}, 32'd0);

    // enable drop in the cycle after a read issues
    b = data_q.size();
    r0 = rd_cnt;
    for (int i = 0; i < 8; i++) push_word(32'(200 + i));
    #1;
    check("en_rd_en", {31'd0, rd_en}, 32'd1);
    @(posedge clk);
    #1 enable = 1'b0;
    #1;
    check("en_rd_off", {31'd0, rd_en}, 32'd0);
    repeat (6) @(negedge clk);
    check("en_rd_pulses", 32'(rd_cnt - r0), 32'd1);
    check("en_beats", 32'(data_q.size() - b), 32'd1);
    if (b < data_q.size()) check("en_inflight_data", data_q[b], 32'd200);
    check("en_drained", {31'd0, tvalid}, 32'd0);
    check("en_beat_persist", {24'd0, beat_cnt}, 32'd1);

    // reset with 2 buffered plus 1 in flight at beat 2
    r0 = rd_cnt;
    enable = 1'b1;
    @(negedge clk);
    check("mr_c1_tvalid", {31'd0, tvalid}, 32'd0);
    @(negedge clk);
    check("mr_c2_tdata", tdata, 32'd201);
    check("mr_c2_beat", {24'd0, beat_cnt}, 32'd1);
    @(negedge clk);
    check("mr_c3_tdata", tdata, 32'd202);
    check("mr_c3_beat", {24'd0, beat_cnt}, 32'd2);
    tready = 1'b0;
    @(negedge clk);
    check("mr_c4_tdata", tdata, 32'd202);
    check("mr_c4_rd_en", {31'd0, rd_en}, 32'd0);
    check("mr_c4_rd_cnt", 32'(rd_cnt - r0), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    check("mr_tvalid", {31'd0, tvalid}, 32'd0);
    check("mr_beat_cnt", {24'd0, beat_cnt}, 32'd0);
    check("mr_tlast", {31'd0, tlast}, 32'd0);
    check("mr_rd_en", {31'd0, rd_en}, 32'd0);
    rst = 1'b0;
    tready = 1'b1;
    b = data_q.size();
    k = 0;
    while (data_q.size() < b + 1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("mr_next_beat_seen", 32'(data_q.size() - b), 32'd1);
    if (b < data_q.size()) check("mr_next_data", data_q[b], 32'd205);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
